ring_phase_monitor: RTL and testbench
=====================================

Name: ring_phase_monitor

Overview:
Downstream checker for the 4-bit one-hot ring counter. Samples the counter's Q bus every clock and locks onto the rotation sequence. Reports the current phase index and counts completed revolutions. Flags non-one-hot values, skipped or reversed steps, and stuck (held) states. Used in simulation and in silicon as a health monitor on any ring-counter-driven sequencer.

Parameters:
DIR, 0, expected rotation: 0 = left (0001->0010->0100->1000->0001), 1 = right (0001->1000->0100->0010->0001)
LOCK_N, 4, consecutive legal advances required to enter LOCKED (1..15)
STUCK_LIM, 8, consecutive repeated samples in LOCKED that raise err_stuck (2..255)
REV_W, 8, width of rev_count

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; highest priority
q_in  input  4  ring counter Q bus
clear_err  input  1  level, sampled on clk; clears sticky errors and restarts sync
locked  output  1  monitor locked to a legal rotation
phase  output  2  index of set bit of last accepted sample (0..3)
rev_count  output  REV_W  completed revolutions since lock, modulo 2^REV_W
err_onehot  output  1  sticky: non-one-hot sample seen while LOCKED
err_seq  output  1  sticky: one-hot sample that was neither hold nor expected rotation, while LOCKED
err_stuck  output  1  sticky: hold limit reached while LOCKED
fault  output  1  monitor in FAULT state

Behaviour:
- Clock and reset: one clock (clk), synchronous active-high reset. All outputs are registered; 1-cycle latency from a sample to its effect on the outputs.
- Reset state: SYNC. q_prev=0, prev_valid=0, good_cnt=0, hold_cnt=0. All outputs 0, phase=0, rev_count=0.
- Sample classes, per edge, comparing q_in with q_prev:
  - ONEHOT: exactly one bit set.
  - ADV: ONEHOT, prev_valid=1, and q_in equals rot(q_prev). Left rotation is {q_prev[2:0],q_prev[3]}; right rotation is {q_prev[0],q_prev[3:1]}.
  - HOLD: ONEHOT and q_in equals q_prev.
  - BAD_SEQ: ONEHOT but neither ADV nor HOLD.
  - BAD_OH: not ONEHOT.
- q_prev is loaded with q_in every cycle. prev_valid is set to ONEHOT every cycle.
- SYNC state:
  - BAD_OH: good_cnt=0.
  - HOLD: good_cnt unchanged.
  - BAD_SEQ, or first valid sample: good_cnt=0; this sample becomes the new reference.
  - ADV: good_cnt+1. When good_cnt reaches LOCK_N, go to LOCKED, set phase=index(q_in), hold_cnt=0, rev_count=0.
  - No error flags are raised in SYNC.
- LOCKED state:
  - ADV: phase=index(q_in), hold_cnt=0. rev_count+1 (wrapping) when the advance lands on phase 0. The lock transition itself never counts a revolution.
  - HOLD: hold_cnt+1. On the STUCK_LIM-th consecutive HOLD, set err_stuck and go to FAULT.
  - BAD_OH: set err_onehot, go to FAULT.
  - BAD_SEQ: set err_seq, go to FAULT.
  - clear_err has no effect.
- FAULT state:
  - fault=1, locked=0. phase and rev_count frozen; error flags sticky.
  - Further bad samples set no additional flags.
  - clear_err=1: all err_* cleared, rev_count=0, good_cnt=0, go to SYNC. The current sample is the new reference.
- Output encoding: locked=1 only in LOCKED; fault=1 only in FAULT.
- Priority: reset > clear_err > error detection.
- Reset asserted mid-operation (any state): the next edge restores full reset values.
- Simultaneous error classes cannot occur; each sample falls in exactly one class.

Test Plan:
1. Lock and count (DIR=0, LOCK_N=4): after reset, drive 0001,0010,0100,1000,0001.
   -> locked=1 on the edge after the 5th sample, phase=0, rev_count=0.
   -> Continue 0010,0100,1000,0001 -> rev_count=1, phase=0. Errors stay 0.
2. Non-one-hot: while locked at phase 1, drive 0011.
   -> Next cycle err_onehot=1, fault=1, locked=0, phase stays 1.
   -> Then drive 0100 -> no new flags.
3. Skip and reverse:
   -> Locked at 0001, drive 0100 -> err_seq=1, fault=1.
   -> After clear_err and relock, drive 1000 then 0100 (reverse) -> err_seq=1.
4. Stuck (STUCK_LIM=8): locked, advance to 1000, then hold 1000.
   -> 7 repeats: no flags.
   -> 8th repeat -> err_stuck=1, fault=1.
5. Clear and relock: in FAULT, pulse clear_err with q_in=0010.
   -> Next cycle all err_*=0, fault=0, rev_count=0.
   -> Then 0100,1000,0001,0010 -> locked=1, phase=1.
6. Reset mid-lock and wrap:
   -> REV_W=2: 4 revolutions -> rev_count returns to 0.
   -> Assert reset while locked -> next cycle all outputs 0, state SYNC.
   -> With DIR=1, drive 0001,1000,0100,0010,0001 -> locked=1.

Source files
------------

// File: rtl/ring_phase_monitor.sv
// Health monitor for a 4-bit one-hot ring counter: locks onto the rotation,
// reports the phase, counts revolutions and latches sequencing faults.
module ring_phase_monitor #(
  parameter int DIR       = 0,
  parameter int LOCK_N    = 4,
  parameter int STUCK_LIM = 8,
  parameter int REV_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       q_in,
  input  logic             clear_err,
  output logic             locked,
  output logic [1:0]       phase,
  output logic [REV_W-1:0] rev_count,
  output logic             err_onehot,
  output logic             err_seq,
  output logic             err_stuck,
  output logic             fault
);

  localparam logic [1:0] S_SYNC  = 2'd0;
  localparam logic [1:0] S_LOCK  = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  localparam logic [3:0]       LOCK_TGT  = 4'(LOCK_N);
  localparam logic [7:0]       STUCK_TGT = 8'(STUCK_LIM);
  localparam logic [REV_W-1:0] REV_ONE   = REV_W'(1);

  logic [1:0] state;
  logic [3:0] q_prev;
  logic       prev_valid;
  logic [3:0] good_cnt;
  logic [7:0] hold_cnt;

  logic       onehot, adv, hold;
  logic [3:0] rot;
  logic [1:0] idx;

  always_comb begin
    onehot = (q_in != 4'd0) && ((q_in & (q_in - 4'd1)) == 4'd0);
    rot    = (DIR == 0) ? {q_prev[2:0], q_prev[3]} : {q_prev[0], q_prev[3:1]};
    adv    = onehot && prev_valid && (q_in == rot);
    hold   = onehot && (q_in == q_prev);
    idx    = 2'd0;
    case (q_in)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  assign locked = (state == S_LOCK);
  assign fault  = (state == S_FAULT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_SYNC;
      q_prev     <= 4'd0;
      prev_valid <= 1'b0;
      good_cnt   <= 4'd0;
      hold_cnt   <= 8'd0;
      phase      <= 2'd0;
      rev_count  <= '0;
      err_onehot <= 1'b0;
      err_seq    <= 1'b0;
      err_stuck  <= 1'b0;
    end else begin
      q_prev     <= q_in;
      prev_valid <= onehot;
      case (state)
        S_SYNC: begin
          // Holds neither help nor hurt; anything else but an advance restarts the count.
          if (clear_err) begin
            good_cnt <= 4'd0;
          end else if (adv) begin
            if (good_cnt + 4'd1 == LOCK_TGT) begin
              state     <= S_LOCK;
              good_cnt  <= 4'd0;
              phase     <= idx;
              hold_cnt  <= 8'd0;
              rev_count <= '0;
            end else begin
              good_cnt <= good_cnt + 4'd1;
            end
          end else if (!hold) begin
            good_cnt <= 4'd0;
          end
        end
        S_LOCK: begin
          if (adv) begin
            phase    <= idx;
            hold_cnt <= 8'd0;
            if (idx == 2'd0) rev_count <= rev_count + REV_ONE;
          end else if (hold) begin
            if (hold_cnt + 8'd1 == STUCK_TGT) begin
              err_stuck <= 1'b1;
              state     <= S_FAULT;
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end else if (!onehot) begin
            err_onehot <= 1'b1;
            state      <= S_FAULT;
          end else begin
            err_seq <= 1'b1;
            state   <= S_FAULT;
          end
        end
        S_FAULT: begin
          if (clear_err) begin
            err_onehot <= 1'b0;
            err_seq    <= 1'b0;
            err_stuck  <= 1'b0;
            rev_count  <= '0;
            good_cnt   <= 4'd0;
            state      <= S_SYNC;
          end
        end
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed bench for ring_phase_monitor: lock, count, fault classes, clear,
// reset, revolution wrap (REV_W=2 copy) and right rotation (DIR=1 copy).
module tb_ring_phase_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] q_in, q2;
  logic       clear_err;
  logic       clr2;

  logic       locked0, err_oh0, err_sq0, err_st0, fault0;
  logic [1:0] phase0;
  logic [7:0] rev0;

  logic       locked1, err_oh1, err_sq1, err_st1, fault1;
  logic [1:0] phase1;
  logic [1:0] rev1;

  logic       locked2, err_oh2, err_sq2, err_st2, fault2;
  logic [1:0] phase2;
  logic [7:0] rev2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ring_phase_monitor #(.DIR(0), .LOCK_N(4), .STUCK_LIM(8), .REV_W(8)) dut0 (
    .clk(clk), .reset(reset), .q_in(q_in), .clear_err(clear_err),
    .locked(locked0), .phase(phase0), .rev_count(rev0),
    .err_onehot(err_oh0), .err_seq(err_sq0), .err_stuck(err_st0), .fault(fault0));

  ring_phase_monitor #(.DIR(0), .LOCK_N(4), .STUCK_LIM(8), .REV_W(2)) dut1 (
    .clk(clk), .reset(reset), .q_in(q_in), .clear_err(clear_err),
    .locked(locked1), .phase(phase1), .rev_count(rev1),
    .err_onehot(err_oh1), .err_seq(err_sq1), .err_stuck(err_st1), .fault(fault1));

  ring_phase_monitor #(.DIR(1), .LOCK_N(4), .STUCK_LIM(8), .REV_W(8)) dut2 (
    .clk(clk), .reset(reset), .q_in(q2), .clear_err(clr2),
    .locked(locked2), .phase(phase2), .rev_count(rev2),
    .err_onehot(err_oh2), .err_seq(err_sq2), .err_stuck(err_st2), .fault(fault2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one sample; outputs are examined 1 time unit after the edge that takes it.
  task automatic drive(input logic [3:0] q, input logic clr);
    q_in      = q;
    clear_err = clr;
    @(posedge clk);
    #1;
    clear_err = 1'b0;
  endtask

  task automatic drive2(input logic [3:0] q);
    q2 = q;
    @(posedge clk);
    #1;
  endtask

  // {locked, fault, err_onehot, err_seq, err_stuck}
  function automatic logic [4:0] st0();
    return {locked0, fault0, err_oh0, err_sq0, err_st0};
  endfunction

  initial begin
    reset = 1'b1; q_in = 4'd0; q2 = 4'd0; clear_err = 1'b0; clr2 = 1'b0;
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);
    chk("reset_dut0", {st0(), phase0, rev0}, 32'd0);
    chk("reset_dut1", {locked1, fault1, err_oh1, err_sq1, err_st1, phase1, rev1}, 32'd0);
    chk("reset_dut2", {locked2, fault2, err_oh2, err_sq2, err_st2, phase2, rev2}, 32'd0);
    reset = 1'b0;

    // Lock and count
    drive(4'b0001, 1'b0); drive(4'b0010, 1'b0); drive(4'b0100, 1'b0); drive(4'b1000, 1'b0);
    chk("prelock_4th", st0(), 5'b00000);
    drive(4'b0001, 1'b0);
    chk("lock_state", st0(), 5'b10000);
    chk("lock_phase", phase0, 2'd0);
    chk("lock_rev", rev0, 8'd0);
    drive(4'b0010, 1'b0); drive(4'b0100, 1'b0); drive(4'b1000, 1'b0);
    chk("mid_phase", phase0, 2'd3);
    drive(4'b0001, 1'b0);
    chk("rev1", rev0, 8'd1);
    chk("rev1_phase", phase0, 2'd0);
    chk("rev1_state", st0(), 5'b10000);

    // Revolution wrap on the REV_W=2 copy
    for (int r = 0; r < 3; r++) begin
      drive(4'b0010, 1'b0); drive(4'b0100, 1'b0); drive(4'b1000, 1'b0); drive(4'b0001, 1'b0);
    end
    chk("rev4_w8", rev0, 8'd4);
    chk("rev4_w2_wrap", rev1, 2'd0);
    chk("rev4_w2_locked", locked1, 1'b1);

    // Non-one-hot while locked at phase 1
    drive(4'b0010, 1'b0);
    chk("p1_phase", phase0, 2'd1);
    drive(4'b0011, 1'b0);
    chk("onehot_state", st0(), 5'b01100);
    chk("onehot_phase", phase0, 2'd1);
    chk("onehot_rev_frozen", rev0, 8'd4);
    drive(4'b0100, 1'b0);
    chk("fault_noflags", st0(), 5'b01100);

    // Clear and relock from 0010
    drive(4'b0010, 1'b1);
    chk("clear_state", st0(), 5'b00000);
    chk("clear_rev", rev0, 8'd0);
    drive(4'b0100, 1'b0); drive(4'b1000, 1'b0); drive(4'b0001, 1'b0);
    chk("relock_pending", locked0, 1'b0);
    drive(4'b0010, 1'b0);
    chk("relock_state", st0(), 5'b10000);
    chk("relock_phase", phase0, 2'd1);

    // Skip: advance to 0001 then jump to 0100
    drive(4'b0100, 1'b0); drive(4'b1000, 1'b0); drive(4'b0001, 1'b0);
    chk("skip_pre_rev", rev0, 8'd1);
    drive(4'b0100, 1'b0);
    chk("skip_state", st0(), 5'b01010);
    chk("skip_phase", phase0, 2'd0);

    // Reverse: relock, reach 1000, step back to 0100
    drive(4'b0001, 1'b1);
    drive(4'b0010, 1'b0); drive(4'b0100, 1'b0); drive(4'b1000, 1'b0); drive(4'b0001, 1'b0);
    chk("rev_relock", st0(), 5'b10000);
    drive(4'b0010, 1'b0); drive(4'b0100, 1'b0); drive(4'b1000, 1'b0);
    drive(4'b0100, 1'b0);
    chk("reverse_state", st0(), 5'b01010);
    chk("reverse_phase", phase0, 2'd3);

    // Stuck: relock landing on 1000 and hold it
    drive(4'b1000, 1'b1);
    drive(4'b0001, 1'b0); drive(4'b0010, 1'b0); drive(4'b0100, 1'b0); drive(4'b1000, 1'b0);
    chk("stuck_lock", st0(), 5'b10000);
    chk("stuck_lock_phase", phase0, 2'd3);
    for (int h = 0; h < 7; h++) drive(4'b1000, 1'b0);
    chk("hold7", st0(), 5'b10000);
    drive(4'b1000, 1'b0);
    chk("hold8", st0(), 5'b01001);
    chk("dut1_hold8", {locked1, fault1, err_oh1, err_sq1, err_st1}, 5'b01001);

    // Reset while locked
    drive(4'b0001, 1'b1);
    drive(4'b0010, 1'b0); drive(4'b0100, 1'b0); drive(4'b1000, 1'b0); drive(4'b0001, 1'b0);
    drive(4'b0010, 1'b0);
    chk("prereset_locked", {locked0, phase0}, {1'b1, 2'd1});
    reset = 1'b1;
    drive(4'b0100, 1'b0);
    reset = 1'b0;
    chk("midreset", {st0(), phase0, rev0}, 32'd0);

    // Right rotation copy
    drive2(4'b0001); drive2(4'b1000); drive2(4'b0100); drive2(4'b0010);
    chk("dir1_prelock", locked2, 1'b0);
    drive2(4'b0001);
    chk("dir1_lock", {locked2, fault2, err_oh2, err_sq2, err_st2, phase2, rev2}, {5'b10000, 2'd0, 8'd0});
    drive2(4'b1000);
    chk("dir1_phase3", phase2, 2'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
